// File: rtl/fog_pkg.sv
// Shared widths, FSM encoding and helpers for the fibre-optic-gyro demodulator.
package fog_pkg;

    localparam int ADC_W   = 14;
    localparam int ACC_W   = 32;
    localparam int DLY_MAX = 255;

    typedef enum logic [0:0] {
        WAIT_EDGE = 1'b0,
        ACC       = 1'b1
    } fog_state_e;

    // Half-periods shorter than two clocks would stall the modulation square wave.
    function automatic logic [15:0] clamp_hp(input logic [15:0] hp);
        return (hp < 16'd2) ? 16'd2 : hp;
    endfunction

endpackage

// File: rtl/fog_delay_line.sv
// Run-time selectable delay of the modulation polarity; tap 0 is a straight wire.
module fog_delay_line #(
    parameter int DEPTH = fog_pkg::DLY_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic [7:0] tap,
    output logic       dout
);
    import fog_pkg::*;

    logic [DEPTH-1:0] sr;
    logic [7:0]       idx;

    // Shift history: sr[k] holds din from k+1 clocks ago.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    // Tap select, saturating at the deepest stage.
    always_comb begin
        idx  = tap - 8'd1;
        dout = din;
        if (tap == 8'd0) begin
            dout = din;
        end else if (32'(tap) > DEPTH) begin
            dout = sr[DEPTH-1];
        end else begin
            dout = sr[idx];
        end
    end

endmodule

// File: rtl/fog_demod_accum.sv
// Square-wave modulation generator with synchronous demodulation of the
// photodetector samples; reports one signed error sum per modulation period.
module fog_demod_accum #(
    parameter int ADC_W   = fog_pkg::ADC_W,
    parameter int ACC_W   = fog_pkg::ACC_W,
    parameter int DLY_MAX = fog_pkg::DLY_MAX
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic signed [ADC_W-1:0] i_adc,
    input  logic                    i_adc_valid,
    input  logic [15:0]             i_half_period,
    input  logic [7:0]              i_delay,
    input  logic [15:0]             i_ignore,
    input  logic [4:0]              i_out_shift,
    output logic                    o_mod,
    output logic signed [ACC_W-1:0] o_err,
    output logic [16:0]             o_cnt,
    output logic signed [ADC_W-1:0] o_meas,
    output logic                    o_err_vld
);
    import fog_pkg::*;

    localparam logic signed [ACC_W-1:0] MEAS_MAX = ACC_W'((1 <<< (ADC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MEAS_MIN = -MEAS_MAX;

    // Symmetric saturation keeps the most negative code out of the filter input.
    function automatic logic signed [ADC_W-1:0] meas_sat(input logic signed [ACC_W-1:0] v,
                                                         input logic [4:0] sh);
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (s > MEAS_MAX) begin
            return MEAS_MAX[ADC_W-1:0];
        end else if (s < MEAS_MIN) begin
            return MEAS_MIN[ADC_W-1:0];
        end else begin
            return s[ADC_W-1:0];
        end
    endfunction

    logic [15:0]             mod_cnt;
    logic [15:0]             hp;
    logic [7:0]              dly;
    logic                    demod_pol;
    logic                    pol_prev;
    logic [15:0]             ign_cnt;
    logic signed [ACC_W-1:0] acc;
    logic [16:0]             cnt;
    fog_state_e              state;

    logic                    rise;
    logic                    edge_any;
    logic [15:0]             ign_eff;
    logic [15:0]             ign_next;
    logic                    take;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] contrib;

    // Modulation counter; period settings are only picked up at the start of a high half.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mod_cnt <= 16'd0;
            o_mod   <= 1'b0;
            hp      <= 16'd2;
            dly     <= 8'd0;
        end else if (mod_cnt == hp - 16'd1) begin
            mod_cnt <= 16'd0;
            o_mod   <= ~o_mod;
            if (!o_mod) begin
                hp  <= clamp_hp(i_half_period);
                dly <= i_delay;
            end
        end else begin
            mod_cnt <= mod_cnt + 16'd1;
        end
    end

    fog_delay_line #(.DEPTH(DLY_MAX)) u_delay_line (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (o_mod),
        .tap  (dly),
        .dout (demod_pol)
    );

    // Sample qualification: the edge-cycle sample sees an ignore count of zero.
    always_comb begin
        rise       = demod_pol & ~pol_prev;
        edge_any   = demod_pol ^ pol_prev;
        ign_eff    = edge_any ? 16'd0 : ign_cnt;
        take       = i_adc_valid && (ign_eff >= i_ignore);
        sample_ext = {{(ACC_W - ADC_W){i_adc[ADC_W-1]}}, i_adc};
        contrib    = '0;
        if (take) begin
            contrib = demod_pol ? sample_ext : -sample_ext;
        end else begin
            contrib = '0;
        end
        if (edge_any) begin
            ign_next = {15'd0, i_adc_valid};
        end else if (i_adc_valid && (ign_cnt < i_ignore)) begin
            ign_next = ign_cnt + 16'd1;
        end else begin
            ign_next = ign_cnt;
        end
    end

    // Accumulator FSM and registered period report.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pol_prev  <= 1'b0;
            ign_cnt   <= 16'd0;
            acc       <= '0;
            cnt       <= 17'd0;
            state     <= WAIT_EDGE;
            o_err     <= '0;
            o_cnt     <= 17'd0;
            o_meas    <= '0;
            o_err_vld <= 1'b0;
        end else begin
            pol_prev  <= demod_pol;
            ign_cnt   <= ign_next;
            o_err_vld <= 1'b0;
            case (state)
                WAIT_EDGE: begin
                    if (rise) begin
                        acc   <= contrib;
                        cnt   <= {16'd0, take};
                        state <= ACC;
                    end else begin
                        acc <= '0;
                        cnt <= 17'd0;
                    end
                end
                ACC: begin
                    if (rise) begin
                        o_err     <= acc;
                        o_cnt     <= cnt;
                        o_meas    <= meas_sat(acc, i_out_shift);
                        o_err_vld <= 1'b1;
                        acc       <= contrib;
                        cnt       <= {16'd0, take};
                    end else begin
                        acc <= acc + contrib;
                        cnt <= cnt + {16'd0, take};
                    end
                end
                default: begin
                    state <= WAIT_EDGE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fog_demod_accum.sv
// Directed, table-driven bench for fog_demod_accum.
`timescale 1ns/1ps
module tb_fog_demod_accum;

    logic               clk;
    logic               i_rst;
    logic signed [13:0] i_adc;
    logic               i_adc_valid;
    logic [15:0]        i_half_period;
    logic [7:0]         i_delay;
    logic [15:0]        i_ignore;
    logic [4:0]         i_out_shift;
    logic               o_mod;
    logic signed [31:0] o_err;
    logic [16:0]        o_cnt;
    logic signed [13:0] o_meas;
    logic               o_err_vld;

    fog_demod_accum dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_adc         (i_adc),
        .i_adc_valid   (i_adc_valid),
        .i_half_period (i_half_period),
        .i_delay       (i_delay),
        .i_ignore      (i_ignore),
        .i_out_shift   (i_out_shift),
        .o_mod         (o_mod),
        .o_err         (o_err),
        .o_cnt         (o_cnt),
        .o_meas        (o_meas),
        .o_err_vld     (o_err_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hp; int dly; int lag; int ign; int sh; int amp; int mode; int vm;
        int exp_err; int exp_cnt; int exp_meas; int exp_int;
    } vec_t;

    vec_t vecs[10];
    int   n_pass = 0;
    int   n_total = 0;

    // Stimulus generator state: mode 0 = +amp when (lagged) o_mod is 1, -amp otherwise; mode 1 = constant
    int          g_amp = 0;
    int          g_mode = 0;
    int          g_lag = 0;
    int          g_vm = 0;
    logic [15:0] mod_hist = 16'd0;
    bit          vphase = 1'b0;

    always @(negedge clk) begin
        int a;
        mod_hist = {mod_hist[14:0], o_mod};
        vphase = ~vphase;
        i_adc_valid = (g_vm == 0) ? 1'b1 : vphase;
        if (g_mode == 1) a = g_amp;
        else a = mod_hist[g_lag] ? g_amp : -g_amp;
        i_adc = a[13:0];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
    endtask

    task automatic wait_strobe(output bit got, output time t);
        got = 1'b0;
        t = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (o_err_vld) begin
                got = 1'b1;
                t = $time;
                return;
            end
        end
        chk("strobe_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mod"}, longint'(o_mod), 0);
        chk({tag, "_err"}, longint'(o_err), 0);
        chk({tag, "_cnt"}, longint'(o_cnt), 0);
        chk({tag, "_meas"}, longint'(o_meas), 0);
        chk({tag, "_vld"}, longint'(o_err_vld), 0);
    endtask

    task automatic set_cfg(input int hp, input int dly, input int lag, input int ign,
                           input int sh, input int amp, input int mode, input int vm);
        i_half_period = 16'(hp);
        i_delay       = 8'(dly);
        i_ignore      = 16'(ign);
        i_out_shift   = 5'(sh);
        g_lag = lag; g_amp = amp; g_mode = mode; g_vm = vm;
    endtask

    initial begin
        bit  got;
        time t1, t2, t3, t4, t5, tr;

        //           hp dly lag ign sh    amp mode vm   err      cnt meas  int
        vecs[0] = '{ 8, 0, 0, 0,  4,  1000, 0, 0,  16000,    16, 1000,  16};
        vecs[1] = '{ 8, 3, 3, 2,  5,  1000, 0, 0,  12000,    12,  375,  16};
        vecs[2] = '{ 8, 0, 0, 0,  0,  8191, 0, 0,  131056,   16, 8191,  16};
        vecs[3] = '{ 8, 0, 0, 0,  0, -8191, 0, 0, -131056,   16, -8191, 16};
        vecs[4] = '{ 8, 0, 0, 0,  0,  8191, 1, 0,  0,        16,    0,  16};
        vecs[5] = '{ 8, 0, 0, 10, 0,  1000, 0, 0,  0,         0,    0,  16};
        vecs[6] = '{ 1, 0, 0, 0,  0,  1000, 0, 0,  4000,      4, 4000,   4};
        vecs[7] = '{ 8, 0, 0, 0,  3,  1000, 0, 1,  8000,      8, 1000,  16};
        vecs[8] = '{ 8, 0, 0, 0,  6, -1000, 0, 0, -16000,    16, -250,  16};
        vecs[9] = '{ 8, 0, 3, 0,  0,  1000, 0, 0,  4000,     16, 4000,  16};

        i_rst = 1'b1;
        i_adc = '0;
        i_adc_valid = 1'b0;
        set_cfg(8, 0, 0, 0, 0, 1000, 0, 0);
        repeat (3) @(negedge clk);
        do_reset();
        chk_zero("reset");

        for (int v = 0; v < 10; v++) begin
            set_cfg(vecs[v].hp, vecs[v].dly, vecs[v].lag, vecs[v].ign,
                    vecs[v].sh, vecs[v].amp, vecs[v].mode, vecs[v].vm);
            do_reset();
            wait_strobe(got, t1);
            if (got) wait_strobe(got, t2);
            if (got) wait_strobe(got, t3);
            if (got) begin
                chk($sformatf("v%0d_err", v), longint'(o_err), vecs[v].exp_err);
                chk($sformatf("v%0d_cnt", v), longint'(o_cnt), vecs[v].exp_cnt);
                chk($sformatf("v%0d_meas", v), longint'(o_meas), vecs[v].exp_meas);
                chk($sformatf("v%0d_interval", v), longint'((t3 - t2) / 10), vecs[v].exp_int);
            end
        end

        // Half-period change in mid high half takes effect only at the next period boundary
        set_cfg(8, 0, 0, 0, 0, 1000, 0, 0);
        do_reset();
        wait_strobe(got, t1);
        if (got) wait_strobe(got, t2);
        if (got) begin
            repeat (3) @(negedge clk);
            i_half_period = 16'd20;
            wait_strobe(got, t3);
        end
        if (got) wait_strobe(got, t4);
        if (got) wait_strobe(got, t5);
        if (got) begin
            chk("hp_chg_int1", longint'((t3 - t2) / 10), 16);
            chk("hp_chg_int2", longint'((t4 - t3) / 10), 40);
            chk("hp_chg_int3", longint'((t5 - t4) / 10), 40);
            chk("hp_chg_err", longint'(o_err), 40000);
            chk("hp_chg_cnt", longint'(o_cnt), 40);
            chk("hp_chg_meas", longint'(o_meas), 8191);
            @(negedge clk);
            chk("hold_vld", longint'(o_err_vld), 0);
            chk("hold_err", longint'(o_err), 40000);
        end

        // Reset pulse five clocks into a period
        set_cfg(8, 0, 0, 0, 0, 1000, 0, 0);
        do_reset();
        wait_strobe(got, t1);
        if (got) wait_strobe(got, t2);
        if (got) begin
            repeat (4) @(negedge clk);
            i_rst = 1'b1;
            @(negedge clk);
            i_rst = 1'b0;
            tr = $time;
            chk_zero("midrst");
            wait_strobe(got, t3);
            if (got) chk("midrst_first_latency", longint'((t3 - tr) / 10), 19);
            if (got) wait_strobe(got, t4);
            if (got) begin
                chk("midrst_err", longint'(o_err), 16000);
                chk("midrst_cnt", longint'(o_cnt), 16);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
